// File: rtl/spi_word_assembler.sv
// spi_word_assembler: packs the 1-bit FIFO read stream into WORD_W-bit words.
// The gated read clock (ser_clk) and its data bit are brought into clk_in
// through a 2-flop synchroniser, and a third flop detects rising edges.
// Bits are shifted in MSB-first. A finished word goes into a 2-entry output
// buffer that drives a valid/ready interface.
// A word that stalls mid-way for GAP_CYC cycles is dropped and flagged on
// frame_err. A finished word that finds the buffer full is dropped and
// flagged on ovf.
// Optional feature: define PARITY_CHECK_EN to expect an even-parity bit after
// each word. A word with bad parity is dropped as a frame error.
//
// state  | meaning
// IDLE   | waiting for the first bit of a word
// SHIFT  | mid-word; collecting bits and timing the gap between rises
module spi_word_assembler #(
  parameter int WORD_W  = 16,
  parameter int GAP_CYC = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              ser_clk,
  input  logic              ser_bit,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              frame_err,
  output logic              ovf,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  ovf_cnt
);

`ifdef PARITY_CHECK_EN
  // The shift register holds every data bit. The parity bit is checked but never stored.
  localparam int SR_W     = WORD_W;
  localparam int LAST_IDX = WORD_W;
`else
  // The last data bit goes straight into the pushed word, so one less stored bit is needed.
  localparam int SR_W     = WORD_W - 1;
  localparam int LAST_IDX = WORD_W - 1;
`endif
  localparam int BC_W  = $clog2(WORD_W + 2);
  localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(LAST_IDX);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_clk_s1, r_clk_s2, r_clk_s3;
  logic               r_bit_s1, r_bit_s2;
  logic [SR_W-1:0]    r_shreg, w_shreg_nxt;
  logic [BC_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [GAP_W-1:0]   r_gap_cnt, w_gap_nxt;
  logic [SR_W:0]      w_shift_full;
  logic               w_rise;
  logic               w_push;
  logic [WORD_W-1:0]  w_push_data;
  logic               w_drop;
  logic               w_pop;
  logic               w_ovf;
  logic [WORD_W-1:0]  r_head, r_tail;
  logic               r_head_vld, r_tail_vld;
  logic               r_frame_err, r_ovf;
  logic [CNT_W-1:0]   r_drop_cnt, r_ovf_cnt;

  assign w_rise       = r_clk_s2 & ~r_clk_s3;
  assign w_shift_full = {r_shreg, r_bit_s2};
  assign w_pop        = r_head_vld & word_ready;
  assign w_ovf        = w_push & ~w_pop & r_tail_vld;

  // Synchronise ser_clk and ser_bit through the same depth so that the bit lines up with the detected rise.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_clk_s1 <= 1'b0;
      r_clk_s2 <= 1'b0;
      r_clk_s3 <= 1'b0;
      r_bit_s1 <= 1'b0;
      r_bit_s2 <= 1'b0;
    end else begin
      r_clk_s1 <= ser_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_bit_s1 <= ser_bit;
      r_bit_s2 <= r_bit_s1;
    end
  end

  // State, shift register, bit counter and gap timer.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Next state: word assembly, completion, and gap timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_push        = 1'b0;
    w_push_data   = '0;
    w_drop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_bit_cnt_nxt = '0;
        w_gap_nxt     = '0;
        if (w_rise) begin
          w_shreg_nxt   = {{(SR_W-1){1'b0}}, r_bit_s2};
          w_bit_cnt_nxt = BC_W'(1);
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_rise) begin
          w_gap_nxt     = '0;
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          w_shreg_nxt   = w_shift_full[SR_W-1:0];
          if (r_bit_cnt == BC_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_bit_cnt_nxt = '0;
`ifdef PARITY_CHECK_EN
            w_shreg_nxt = r_shreg;
            w_push_data = r_shreg;
            if (^w_shift_full) w_drop = 1'b1;
            else               w_push = 1'b1;
`else
            w_push_data = w_shift_full;
            w_push      = 1'b1;
`endif
          end
        end else if (r_gap_cnt == GAP_LAST) begin
          w_drop        = 1'b1;
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = '0;
          w_gap_nxt     = '0;
        end else begin
          w_gap_nxt = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // 2-entry output buffer. A pop frees a slot in the same cycle, so a push to a full buffer during a pop is kept.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else if (w_pop) begin
      if (r_tail_vld) begin
        r_head <= r_tail;
        if (w_push) r_tail     <= w_push_data;
        else        r_tail_vld <= 1'b0;
      end else if (w_push) begin
        r_head <= w_push_data;
      end else begin
        r_head_vld <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_head_vld) begin
        r_head     <= w_push_data;
        r_head_vld <= 1'b1;
      end else if (!r_tail_vld) begin
        r_tail     <= w_push_data;
        r_tail_vld <= 1'b1;
      end
    end
  end

  // Error pulses and their saturating event counters.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_frame_err <= 1'b0;
      r_ovf       <= 1'b0;
      r_drop_cnt  <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      r_frame_err <= w_drop;
      r_ovf       <= w_ovf;
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
      if (w_ovf && (r_ovf_cnt != '1))   r_ovf_cnt  <= r_ovf_cnt + 1'b1;
    end
  end

  assign word_data  = r_head;
  assign word_valid = r_head_vld;
  assign frame_err  = r_frame_err;
  assign ovf        = r_ovf;
  assign drop_cnt   = r_drop_cnt;
  assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_spi_word_assembler.sv
// Testbench for spi_word_assembler.
// The DUT is built with CNT_W=2 so that counter saturation can be reached quickly.
module tb_spi_word_assembler;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 2;
`ifdef PARITY_CHECK_EN
  localparam int NB = WORD_W + 1;
`else
  localparam int NB = WORD_W;
`endif

  logic              clk_in = 1'b0;
  logic              rst;
  logic              ser_clk;
  logic              ser_bit;
  logic              word_ready;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              frame_err;
  logic              ovf;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  ovf_cnt;

  spi_word_assembler #(.WORD_W(WORD_W), .GAP_CYC(64), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst(rst), .ser_clk(ser_clk), .ser_bit(ser_bit),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .frame_err(frame_err), .ovf(ovf), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;
  int fe_pulses = 0;
  int ovf_pulses = 0;
  int stall_err = 0;
  logic [WORD_W-1:0] rx_q[$];
  logic              prev_stall = 1'b0;
  logic [WORD_W-1:0] prev_data = '0;

  // Monitor, sampling 2 time units after each negedge: transfers, pulse counts, and stability under backpressure.
  always begin
    @(negedge clk_in);
    #2;
    if (!rst) begin
      if (prev_stall && (!word_valid || word_data !== prev_data)) stall_err++;
      if (word_valid && word_ready) rx_q.push_back(word_data);
      if (frame_err) fe_pulses++;
      if (ovf) ovf_pulses++;
    end
    prev_stall = word_valid && !word_ready && !rst;
    prev_data  = word_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bit_at(input logic [WORD_W-1:0] w, input int i);
    if (i < WORD_W) return w[WORD_W-1-i];
    return ^w;
  endfunction

  // Low phase with the new bit on ser_bit, then drive ser_clk high; returns on the negedge where ser_clk rose.
  task automatic start_bit(input logic b);
    @(negedge clk_in);
    ser_bit = b;
    ser_clk = 1'b0;
    repeat (3) @(negedge clk_in);
    ser_clk = 1'b1;
  endtask

  task automatic send_bit(input logic b);
    start_bit(b);
    repeat (3) @(negedge clk_in);
  endtask

  task automatic send_bits(input logic [WORD_W-1:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(bit_at(w, i));
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    send_bits(w, NB);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    ser_clk = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk_in);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);
    rx_q.delete();
  endtask

  typedef struct {
    logic [WORD_W-1:0] word;
    int                stall;
    logic [WORD_W-1:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   fe0, ov0;

  initial begin
    vecs[0] = '{16'h0000, 0, 16'h0000};
    vecs[1] = '{16'hFFFF, 0, 16'hFFFF};
    vecs[2] = '{16'h8001, 5, 16'h8001};
    vecs[3] = '{16'h7FFE, 0, 16'h7FFE};
    vecs[4] = '{16'h5A5A, 8, 16'h5A5A};
    vecs[5] = '{16'h0F0F, 0, 16'h0F0F};

    rst = 1'b1; ser_clk = 1'b0; ser_bit = 1'b0; word_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_valid", 32'(word_valid), 0);
    check("rst_data", 32'(word_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);

    // First word: check latency cycle by cycle around the last sample.
    word_ready = 1'b1;
    send_bits(16'hA5C3, NB - 1);
    start_bit(bit_at(16'hA5C3, NB - 1));
    @(negedge clk_in); check("lat_n1_valid", 32'(word_valid), 0);
    @(negedge clk_in); check("lat_n2_valid", 32'(word_valid), 0);
    @(negedge clk_in); check("lat_n3_valid", 32'(word_valid), 1);
    check("lat_n3_data", 32'(word_data), 32'h0000A5C3);
    @(negedge clk_in); check("lat_n4_valid", 32'(word_valid), 0);
    repeat (2) @(negedge clk_in);
    check("a5c3_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("a5c3_data", 32'(rx_q[0]), 32'h0000A5C3);
    rx_q.delete();

    // Table of single words, some held under backpressure before they are accepted.
    for (int i = 0; i < 6; i++) begin
      word_ready = (vecs[i].stall == 0);
      send_word(vecs[i].word);
      repeat (3) @(negedge clk_in);
      if (vecs[i].stall > 0) begin
        check("vec_hold_valid", 32'(word_valid), 1);
        check("vec_hold_data", 32'(word_data), 32'(vecs[i].exp));
        repeat (vecs[i].stall) @(negedge clk_in);
        word_ready = 1'b1;
        repeat (3) @(negedge clk_in);
      end
      check("vec_count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("vec_data", 32'(rx_q.pop_front()), 32'(vecs[i].exp));
      rx_q.delete();
    end

    // Truncated burst: 5 bits, then the gap timeout fires 64 cycles after the last rise.
    fe0 = fe_pulses;
    send_bits(16'hFFFF, 5);
    repeat (63) @(negedge clk_in);
    check("gap_early_fe", 32'(frame_err), 0);
    @(negedge clk_in);
    check("gap_fe_pulse", 32'(frame_err), 1);
    check("gap_drop_cnt", 32'(drop_cnt), 1);
    @(negedge clk_in);
    check("gap_fe_single", 32'(frame_err), 0);
    repeat (4) @(negedge clk_in);
    check("gap_fe_count", fe_pulses - fe0, 1);
    check("gap_no_word", rx_q.size(), 0);
    send_word(16'h1234);
    repeat (3) @(negedge clk_in);
    check("gap_next_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("gap_next_data", 32'(rx_q[0]), 32'h00001234);
    rx_q.delete();

    // Overflow: three words arrive with ready low, so the third one is lost.
    ov0 = ovf_pulses;
    word_ready = 1'b0;
    send_word(16'h0001);
    send_word(16'h0002);
    send_word(16'h0003);
    repeat (2) @(negedge clk_in);
    check("ovf_pulses", ovf_pulses - ov0, 1);
    check("ovf_cnt", 32'(ovf_cnt), 1);
    check("ovf_head_valid", 32'(word_valid), 1);
    check("ovf_head_data", 32'(word_data), 32'h00000001);
    repeat (10) @(negedge clk_in);
    word_ready = 1'b1;
    repeat (4) @(negedge clk_in);
    check("ovf_drain_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("ovf_drain_0", 32'(rx_q[0]), 32'h00000001);
      check("ovf_drain_1", 32'(rx_q[1]), 32'h00000002);
    end
    rx_q.delete();

    // Buffer full, and a word completes in the same cycle as a pop.
    ov0 = ovf_pulses;
    word_ready = 1'b0;
    send_word(16'h0011);
    send_word(16'h0022);
    send_bits(16'h0033, NB - 1);
    start_bit(bit_at(16'h0033, NB - 1));
    repeat (2) @(negedge clk_in);
    word_ready = 1'b1;
    @(negedge clk_in);
    word_ready = 1'b0;
    check("pp_no_ovf", 32'(ovf), 0);
    check("pp_head_data", 32'(word_data), 32'h00000022);
    repeat (5) @(negedge clk_in);
    word_ready = 1'b1;
    repeat (5) @(negedge clk_in);
    check("pp_ovf_pulses", ovf_pulses - ov0, 0);
    check("pp_ovf_cnt", 32'(ovf_cnt), 1);
    check("pp_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check("pp_order_0", 32'(rx_q[0]), 32'h00000011);
      check("pp_order_1", 32'(rx_q[1]), 32'h00000022);
      check("pp_order_2", 32'(rx_q[2]), 32'h00000033);
    end
    rx_q.delete();

    // Reset in the middle of a word drops it silently.
    fe0 = fe_pulses;
    send_bits(16'h5555, 8);
    do_reset();
    send_word(16'hFFFF);
    repeat (3) @(negedge clk_in);
    check("rstmid_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("rstmid_data", 32'(rx_q[0]), 32'h0000FFFF);
    check("rstmid_drop_cnt", 32'(drop_cnt), 0);
    check("rstmid_fe", fe_pulses - fe0, 0);
    rx_q.delete();

`ifdef PARITY_CHECK_EN
    fe0 = fe_pulses;
    send_bits(16'h00FF, WORD_W);
    send_bit(1'b0);
    repeat (3) @(negedge clk_in);
    check("par_good_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("par_good_data", 32'(rx_q[0]), 32'h000000FF);
    rx_q.delete();
    send_bits(16'h00FF, WORD_W);
    send_bit(1'b1);
    repeat (3) @(negedge clk_in);
    check("par_bad_count", rx_q.size(), 0);
    check("par_bad_fe", fe_pulses - fe0, 1);
    check("par_bad_drop_cnt", 32'(drop_cnt), 1);
    rx_q.delete();
`endif

    // Counter saturation with the 2-bit counters.
    do_reset();
    ov0 = ovf_pulses;
    fe0 = fe_pulses;
    word_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_word(16'(i * 16'h0101));
    repeat (2) @(negedge clk_in);
    check("sat_ovf_cnt_3", 32'(ovf_cnt), 3);
    send_word(16'h0606);
    repeat (2) @(negedge clk_in);
    check("sat_ovf_cnt_hold", 32'(ovf_cnt), 3);
    check("sat_ovf_pulses", ovf_pulses - ov0, 4);
    word_ready = 1'b1;
    repeat (4) @(negedge clk_in);
    check("sat_drain_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("sat_drain_0", 32'(rx_q[0]), 32'h00000101);
      check("sat_drain_1", 32'(rx_q[1]), 32'h00000202);
    end
    rx_q.delete();
    for (int i = 0; i < 4; i++) begin
      send_bits(16'h8000, 1);
      repeat (70) @(negedge clk_in);
    end
    check("sat_drop_cnt", 32'(drop_cnt), 3);
    check("sat_fe_pulses", fe_pulses - fe0, 4);
    check("sat_no_word", rx_q.size(), 0);

    check("stall_stability", stall_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
